// File: rtl/cpu_pkg.sv
// cpu_pkg: ID/EX pipeline control and data record types plus the zero-control bubble constant.
package cpu_pkg;
  typedef struct packed {
    logic       WB_reg_write;
    logic       WB_mem_to_reg;
    logic       M_mem_read;
    logic       M_mem_write;
    logic       M_branch;
    logic       EX_alu_src;
    logic [1:0] EX_ALU_Op;
  } pipeline_control_t;
  typedef struct packed {
    logic [31:0] pc_address;
    logic [31:0] reg_read_data1;
    logic [31:0] reg_read_data2;
    logic [31:0] imm;
    logic [3:0]  funct_inst_bits;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } pipeline_data_t;
  localparam pipeline_control_t CTRL_NOP = '0;
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: combinational load-use detect and PC / IF-ID write enables.
module hazard_unit (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       hold_i,
  output logic       load_use_stall_o,
  output logic       pc_write_en_o,
  output logic       if_id_write_en_o
);
  always_comb begin
    load_use_stall_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) && id_valid_i &&
                       ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    pc_write_en_o    = !(load_use_stall_o || hold_i);
    if_id_write_en_o = pc_write_en_o;
  end
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with flush, hold, load-use bubble insertion
// and a saturating bubble counter.
module id_ex_reg
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pipeline_control_t ctrl_in,
  input  pipeline_data_t    data_in,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              hold,
  output pipeline_control_t ctrl_out,
  output pipeline_data_t    data_out,
  output logic              valid_out,
  output logic              load_use_stall,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic [CNT_W-1:0]  stall_cnt
);
  pipeline_control_t ctrl_q, ctrl_d;
  pipeline_data_t    data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bubble;
  hazard_unit u_hazard (
    .ex_valid_i       (valid_q),
    .ex_mem_read_i    (ctrl_q.M_mem_read),
    .ex_rd_i          (data_q.rd),
    .id_valid_i       (id_valid),
    .id_rs1_i         (data_in.rs1),
    .id_rs2_i         (data_in.rs2),
    .hold_i           (hold),
    .load_use_stall_o (load_use_stall),
    .pc_write_en_o    (pc_write_en),
    .if_id_write_en_o (if_id_write_en)
  );
  // flush outranks hold, so a killed instruction never lingers in a frozen stage
  always_comb begin
    bubble  = !flush && !hold && load_use_stall;
    ctrl_d  = flush ? CTRL_NOP : hold ? ctrl_q : load_use_stall ? CTRL_NOP : id_valid ? ctrl_in : CTRL_NOP;
    data_d  = (hold && !flush) ? data_q : data_in;
    valid_d = flush ? 1'b0 : hold ? valid_q : load_use_stall ? 1'b0 : id_valid;
    cnt_d   = (bubble && !(&cnt_q)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_NOP;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign ctrl_out  = ctrl_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: randomized and directed stimulus scored against a rule-level model of the ID/EX stage.
module tb_id_ex_reg;
  import cpu_pkg::*;
  typedef struct {
    pipeline_control_t c;
    pipeline_data_t    d;
    logic              v;
    logic [1:0]        n;
  } exp_t;
  logic              clk = 1'b0;
  logic              rst_n;
  pipeline_control_t ctrl_in, ctrl_out;
  pipeline_data_t    data_in, data_out;
  logic              id_valid, flush, hold;
  logic              valid_out, load_use_stall, pc_write_en, if_id_write_en;
  logic [1:0]        stall_cnt;
  int                checks = 0;
  int                failures = 0;
  exp_t              sb[$];
  pipeline_control_t m_ctrl;
  pipeline_data_t    m_data;
  logic              m_valid;
  int                m_cnt;
  id_ex_reg #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_in(ctrl_in), .data_in(data_in), .id_valid(id_valid),
    .flush(flush), .hold(hold), .ctrl_out(ctrl_out), .data_out(data_out), .valid_out(valid_out),
    .load_use_stall(load_use_stall), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [146:0] act, input logic [146:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  function automatic pipeline_data_t rnd_data();
    pipeline_data_t d;
    d.pc_address      = $urandom;
    d.reg_read_data1  = $urandom;
    d.reg_read_data2  = $urandom;
    d.imm             = $urandom;
    d.funct_inst_bits = 4'($urandom);
    d.rd              = 5'($urandom_range(0, 3));
    d.rs1             = 5'($urandom_range(0, 3));
    d.rs2             = 5'($urandom_range(0, 3));
    return d;
  endfunction
  function automatic pipeline_control_t load_ctrl();
    pipeline_control_t c;
    c = pipeline_control_t'(8'($urandom));
    c.M_mem_read = 1'b1;
    return c;
  endfunction
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input pipeline_control_t c, input pipeline_data_t d, input logic v,
                     input logic f, input logic h);
    logic stall;
    exp_t e;
    ctrl_in = c; data_in = d; id_valid = v; flush = f; hold = h;
    #1;
    stall = m_valid && m_ctrl.M_mem_read && m_data.rd != 0 && v && (m_data.rd == d.rs1 || m_data.rd == d.rs2);
    chk("load_use_stall", 147'(load_use_stall), 147'(stall));
    chk("pc_write_en", 147'(pc_write_en), 147'(!(stall || h)));
    chk("if_id_write_en", 147'(if_id_write_en), 147'(!(stall || h)));
    if (f) begin
      m_ctrl = '0; m_valid = 1'b0; m_data = d;
    end else if (h) begin
    end else if (stall) begin
      m_ctrl = '0; m_valid = 1'b0; m_data = d;
      m_cnt = (m_cnt >= 3) ? 3 : m_cnt + 1;
    end else begin
      m_ctrl = v ? c : '0; m_valid = v; m_data = d;
    end
    e.c = m_ctrl; e.d = m_data; e.v = m_valid; e.n = 2'(m_cnt);
    sb.push_back(e);
    @(negedge clk);
  endtask
  task automatic reset_pulse();
    ctrl_in = '0; data_in = '0; id_valid = 1'b0; flush = 1'b0; hold = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst ctrl_out", 147'(ctrl_out), 147'(0));
    chk("rst data_out", 147'(data_out), 147'(0));
    chk("rst valid_out", 147'(valid_out), 147'(0));
    chk("rst stall_cnt", 147'(stall_cnt), 147'(0));
    chk("rst load_use_stall", 147'(load_use_stall), 147'(0));
    chk("rst pc_write_en", 147'(pc_write_en), 147'(1));
    m_ctrl = '0; m_data = '0; m_valid = 1'b0; m_cnt = 0;
    #1 rst_n = 1'b1;
  endtask
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctrl_out", 147'(ctrl_out), 147'(e.c));
      chk("data_out", 147'(data_out), 147'(e.d));
      chk("valid_out", 147'(valid_out), 147'(e.v));
      chk("stall_cnt", 147'(stall_cnt), 147'(e.n));
    end
  end
  initial begin
    pipeline_control_t c;
    pipeline_data_t    d;
    @(negedge clk);
    reset_pulse();
    c = '0; c.EX_ALU_Op = 2'b10;
    d = rnd_data(); d.imm = 32'h0000_0010;
    cyc(c, d, 1'b1, 1'b0, 1'b0);
    chk("normal valid_out", 147'(valid_out), 147'(1));
    d = rnd_data(); d.rd = 5'd5;
    cyc(load_ctrl(), d, 1'b1, 1'b0, 1'b0);
    d = rnd_data(); d.rs1 = 5'd5;
    cyc(pipeline_control_t'(8'($urandom)), d, 1'b1, 1'b0, 1'b0);
    chk("lu bubble valid_out", 147'(valid_out), 147'(0));
    chk("lu stall_cnt", 147'(stall_cnt), 147'(1));
    cyc(pipeline_control_t'(8'($urandom)), d, 1'b1, 1'b0, 1'b0);
    chk("lu reload valid_out", 147'(valid_out), 147'(1));
    d = rnd_data(); d.rd = 5'd0;
    cyc(load_ctrl(), d, 1'b1, 1'b0, 1'b0);
    d = rnd_data(); d.rs1 = 5'd0;
    cyc(pipeline_control_t'(8'($urandom)), d, 1'b1, 1'b0, 1'b0);
    d = rnd_data(); d.rd = 5'd5;
    cyc(load_ctrl(), d, 1'b1, 1'b0, 1'b0);
    d = rnd_data(); d.rs1 = 5'd5;
    cyc(pipeline_control_t'(8'($urandom)), d, 1'b1, 1'b1, 1'b1);
    cyc(load_ctrl(), rnd_data(), 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(pipeline_control_t'(8'($urandom)), rnd_data(), 1'b1, 1'b0, 1'b1);
    repeat (5) begin
      d = rnd_data(); d.rd = 5'd7;
      cyc(load_ctrl(), d, 1'b1, 1'b0, 1'b0);
      d = rnd_data(); d.rs2 = 5'd7;
      cyc(pipeline_control_t'(8'($urandom)), d, 1'b1, 1'b0, 1'b0);
    end
    chk("sat stall_cnt", 147'(stall_cnt), 147'(3));
    cyc(load_ctrl(), rnd_data(), 1'b1, 1'b0, 1'b0);
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_pulse();
      cyc(pipeline_control_t'(8'($urandom)) | (($urandom_range(0, 1) != 0) ? load_ctrl() : CTRL_NOP),
          rnd_data(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    chk("scoreboard drained", 147'(sb.size()), 147'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the load-use stall counter.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port ctrl_in, input, pipeline_control_t (8), ID-stage decoded control (WB, M, EX fields).
REQ-005 SHALL have port data_in, input, pipeline_data_t (147), carries pc_address, reg_read_data1/2, imm, funct_inst_bits, rd, rs1, rs2.
REQ-006 SHALL have port id_valid, input, 1, the ID stage holds a real instruction.
REQ-007 SHALL have port flush, input, 1, branch resolved taken; kill the instruction entering EX.
REQ-008 SHALL have port hold, input, 1, global downstream stall; freeze this register.
REQ-009 SHALL have port ctrl_out, output, pipeline_control_t, registered EX-stage control.
REQ-010 SHALL have port data_out, output, pipeline_data_t, registered EX-stage data.
REQ-011 SHALL have port valid_out, output, 1, ctrl_out/data_out hold a real instruction.
REQ-012 SHALL have port load_use_stall, output, 1, combinational load-use hazard detect.
REQ-013 SHALL have port pc_write_en, output, 1, PC register enable.
REQ-014 SHALL have port if_id_write_en, output, 1, IF/ID register enable.
REQ-015 SHALL have port stall_cnt, output, CNT_W, count of inserted load-use bubbles.

Function
REQ-016 load_use_stall SHALL be 1 iff valid_out & ctrl_out.M_mem_read & data_out.rd!=0 & id_valid & (data_out.rd==data_in.rs1 | data_out.rd==data_in.rs2).
REQ-017 pc_write_en and if_id_write_en SHALL both be ~(load_use_stall | hold) (flush does not deassert them).
REQ-018 Per rising edge, priority SHALL be: flush > hold > load_use_stall > normal load.
REQ-019 flush SHALL clear ctrl_out to all-zero and valid_out to 0 next edge, even with hold=1; data_out captures data_in.
REQ-020 hold (no flush) SHALL retain ctrl_out, data_out, valid_out, and stall_cnt unchanged.
REQ-021 load_use_stall (no flush/hold) SHALL insert a bubble: ctrl_out all-zero, valid_out=0, data_out captures data_in.
REQ-022 Normal load SHALL capture ctrl_in, data_in, and valid_out<=id_valid; if id_valid=0, ctrl_out SHALL be all-zero.
REQ-023 Latency ID->EX SHALL be exactly one cycle on the normal path.
REQ-024 stall_cnt SHALL increment by 1 on each edge executing REQ-021, saturate at 2^CNT_W-1, and never wrap.
REQ-025 A bubble SHALL never itself cause load_use_stall (valid_out=0 masks it), so a load-use stall lasts exactly one cycle.
REQ-026 rd==0 loads SHALL never stall.

Reset
REQ-027 rst_n low SHALL immediately force ctrl_out=0, data_out=0, valid_out=0, stall_cnt=0, independent of clk.
REQ-028 Therefore, during reset, load_use_stall=0 and pc_write_en=if_id_write_en=1 (when hold=0).
REQ-029 Reset deassertion mid-stream SHALL resume at normal load on the first edge; no residual bubble.

Structure
REQ-030 pipeline_control_t and pipeline_data_t (with added 5-bit rs1, rs2 fields) SHALL live in cpu_pkg as packed structs; the zero-control constant CTRL_NOP SHALL live there too.
REQ-031 Hazard detection SHALL be a separate sub-module hazard_unit (combinational, REQ-016/017); the register and counter stay in id_ex_reg.

Verification
REQ-032 Normal: ctrl_in.EX_ALU_Op=2'b10, data_in.imm=32'h0000_0010, id_valid=1 -> next edge ctrl_out/data_out match, valid_out=1.
REQ-033 Load-use: EX holds lw rd=5 (M_mem_read=1), ID rs1=5 -> load_use_stall=1, pc_write_en=0; next edge valid_out=0, ctrl_out=0, stall_cnt=1; following edge the instruction loads normally.
REQ-034 rd=0 load with ID rs1=0 -> load_use_stall=0, no bubble, stall_cnt unchanged.
REQ-035 flush=1 with hold=1 and a pending load-use -> next edge valid_out=0, ctrl_out=0, stall_cnt unchanged.
REQ-036 hold=1 for 3 cycles -> outputs and stall_cnt frozen, pc_write_en=0; CNT_W=2 with 5 load-use bubbles -> stall_cnt saturates at 3.
REQ-037 rst_n pulsed low between clock edges with valid_out=1 -> outputs zero immediately, before the next edge.
